deser5_rx: RTL and testbench
============================

# deser5_rx

Serial-to-parallel receiver that collects a bit stream into 5-bit words, one bit per handshake, and presents each completed word through a valid/ready output port with a registered all-zeros flag. It sits in the ECP2 simulation library next to the 5-input gate cells. It is the word-assembly end of a 5-bit serial link: it rebuilds parallel words that an upstream shifter sends one bit at a time. One accumulating shift register plus one holding register give single-word slack before backpressure reaches the serial side.

## Interface
Parameters:
- LSBF, default 1: 1 = first received bit lands in Q[0]; 0 = first received bit lands in Q[4].

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  synchronous, active-high reset.
- SDI  input  1  serial data bit.
- SDV  input  1  SDI is valid this cycle.
- SRDY  output  1  receiver can accept a bit; a bit transfers when SDV && SRDY at the CLK edge.
- SCLR  input  1  synchronous discard of the partially assembled word.
- Q  output  5  assembled word, registered.
- QV  output  1  Q holds a word not yet consumed.
- QR  input  1  consumer ready; the word transfers when QV && QR at the CLK edge.
- ZN  output  1  5-input NOR of Q (1 when Q == 5'b00000).

## Operation
- State: shift register SH[4:0]; bit counter CNT in 0..5 (3 bits); holding register Q with flag QV.
- Bit accept (SDV && SRDY, no SCLR):
  - The bit goes into SH at position CNT (LSBF=1) or 4-CNT (LSBF=0).
  - CNT increments.
- Fifth bit accepted (CNT==4), routing depends on the holding register:
  - If !QV || QR: the completed word (SH plus the new bit) loads Q directly, QV=1, CNT→0.
  - Otherwise: the word stays in SH, CNT→5 (pending).
- Pending state (CNT==5): SRDY=0. On the first edge with QR=1, Q←SH, QV stays 1, CNT→0.
- Consume without reload (QV && QR, nothing to load): QV→0. Q keeps its last value.
- SRDY = (CNT != 5). It is combinational from CNT only, with no dependence on QR.
- SCLR:
  - CNT→0 and SH is discarded, including a pending CNT==5 word.
  - Q, QV and the consume path are unaffected.
  - SCLR wins over a simultaneous SDV, and that bit is dropped.
- ZN = ~|Q, combinational from the Q register.
- Unused SH bits carry no meaning. Q only ever loads a complete 5-bit word.

## Timing
- Reset values: Q=0, QV=0, ZN=1, SRDY=1, CNT=0. SH is cleared to 0.
- RST overrides everything, including a transfer in progress. A partial word and the held word are both lost.
- Latency: QV rises on the same edge that samples the fifth bit when the holding register is free. Q is valid 0 cycles after that edge.
- Throughput: one bit per cycle sustained, one word per 5 cycles, with no bubbles while QR stays high.
- Backpressure: at most 5 bits plus one held word are buffered. The sixth-word bit stalls (SRDY=0) until QR is seen.
- Simultaneous events on one edge:
  - Fifth bit plus QV&&QR: Q reloads and QV stays 1.
  - Consume plus SCLR: QV→0 and CNT→0.
  - SDV with SRDY=0: no effect, and SDI is ignored.
- SDI, SDV, SCLR and QR are sampled only at the CLK edge. X on SDI when SDV=0 must not propagate.

## Structure
- Shared package deser5_pkg:
  - localparam WORD_W = 5.
  - localparam CNT_W = 3.
  - localparam CNT_FULL = 3'd5.
- One sub-module is natural: deser5_shift (SH plus CNT, insert position by LSBF, pending flag). The top level holds Q/QV and the handshake.
- No other cells are instantiated. ZN is a plain reduction.

## Test plan
- Reset, then LSBF=1, SDV=1 with bits 1,0,1,1,0 on 5 consecutive cycles, QR=1 → QV rises on the 5th edge, Q=5'b01101, ZN=0, SRDY stays 1.
- LSBF=0, same bit sequence → Q=5'b10110. Then send 0,0,0,0,0 → Q=5'b00000 and ZN=1.
- QR=0 and 10 bits offered back-to-back → first word held in Q. SRDY drops after the 10th bit (CNT=5). Raising QR for 1 cycle → Q becomes the second word, QV stays 1, SRDY returns to 1 on the next cycle.
- 3 bits accepted, then SCLR asserted together with SDV=1 → bit dropped, CNT=0. The next 5 bits form a fresh word, and a word already in Q is untouched.
- Continuous stream for 20 words with QR=1 → no SRDY deassertion, one QV pulse-word per 5 cycles, data matches the reference model.
- RST asserted while CNT=5 and QV=1 → next cycle Q=0, QV=0, ZN=1, SRDY=1.

Source files
------------

// File: rtl/deser5_pkg.sv
// Shared constants and helpers for the 5-bit serial-to-parallel receiver.
// ins_pos maps the count of bits already received to the slot the next bit fills.
package deser5_pkg;

  localparam int WORD_W = 5;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_FULL = 3'd5;
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd4;

  typedef logic [WORD_W-1:0] word_t;

  function automatic logic [CNT_W-1:0] ins_pos(input logic [CNT_W-1:0] cnt,
                                               input logic lsbf);
    return lsbf ? cnt : (CNT_LAST - cnt);
  endfunction

endpackage

// File: rtl/deser5_rx_if.sv
// Serial-in / word-out port bundle of deser5_rx. The master drives the bit stream
// and consumes words. The slave is the receiver itself.
interface deser5_rx_if;
  import deser5_pkg::*;

  // Handshakes: a bit moves on a CLK edge with SDV && SRDY, and a word moves on a
  // CLK edge with QV && QR. Neither valid may wait for ready, SRDY depends only on
  // the receiver's internal count, and SDI is ignored whenever SDV is low.
  logic             SDI;
  logic             SDV;
  logic             SRDY;
  logic             SCLR;
  word_t            Q;
  logic             QV;
  logic             QR;
  logic             ZN;
  logic [CNT_W-1:0] CNT_DBG;

  modport master (output SDI, SDV, SCLR, QR,
                  input  SRDY, Q, QV, ZN, CNT_DBG);
  modport slave  (input  SDI, SDV, SCLR, QR,
                  output SRDY, Q, QV, ZN, CNT_DBG);
endinterface

// File: rtl/deser5_shift.sv
// Accumulates serial bits into a 5-bit shift word. A completed word is parked
// (count 5) while the holding register downstream is occupied.
module deser5_shift
  import deser5_pkg::*;
#(
  parameter bit LSBF = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sclr_i,
  input  logic             bit_i,
  input  logic             bit_vld_i,
  input  logic             room_i,
  input  logic             take_i,
  output word_t            word_o,
  output logic             load_o,
  output logic             srdy_o,
  output logic [CNT_W-1:0] cnt_o
);

  word_t            sh_q, sh_d, sh_ins;
  logic [CNT_W-1:0] cnt_q, cnt_d, pos;
  logic             pend, accept;

  always_comb begin
    pend   = (cnt_q == CNT_FULL);
    accept = bit_vld_i && !pend;
    pos    = ins_pos(cnt_q, LSBF);
    sh_ins = sh_q;
    for (int i = 0; i < WORD_W; i++) begin
      if (pos == CNT_W'(i)) sh_ins[i] = bit_i;
    end

    sh_d   = sh_q;
    cnt_d  = cnt_q;
    load_o = 1'b0;
    // A parked word is already complete in sh_q; otherwise the word includes the incoming bit.
    word_o = pend ? sh_q : sh_ins;

    if (sclr_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (pend) begin
      if (take_i) begin
        load_o = 1'b1;
        cnt_d  = '0;
      end
    end else if (accept) begin
      sh_d = sh_ins;
      if (cnt_q == CNT_LAST) begin
        if (room_i) begin
          load_o = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = CNT_FULL;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign srdy_o = !pend;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/deser5_rx.sv
// 5-bit serial receiver: the shift stage assembles words, this level holds one
// finished word in Q/QV until the consumer takes it.
module deser5_rx
  import deser5_pkg::*;
#(
  parameter bit LSBF = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  deser5_rx_if.slave  bus
);

  word_t            word, q_q, q_d;
  logic             load, srdy, room;
  logic             qv_q, qv_d;
  logic [CNT_W-1:0] cnt;

  // The holding register is free for a new word if empty or being consumed this edge.
  assign room = !qv_q || bus.QR;

  deser5_shift #(.LSBF(LSBF)) u_shift (
    .clk_i     (CLK),
    .rst_i     (RST),
    .sclr_i    (bus.SCLR),
    .bit_i     (bus.SDI),
    .bit_vld_i (bus.SDV),
    .room_i    (room),
    .take_i    (bus.QR),
    .word_o    (word),
    .load_o    (load),
    .srdy_o    (srdy),
    .cnt_o     (cnt)
  );

  always_comb begin
    q_d  = q_q;
    qv_d = qv_q;
    if (load) begin
      q_d  = word;
      qv_d = 1'b1;
    end else if (qv_q && bus.QR) begin
      qv_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q  <= '0;
      qv_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      qv_q <= qv_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.QV      = qv_q;
  assign bus.ZN      = ~|q_q;
  assign bus.SRDY    = srdy;
  assign bus.CNT_DBG = cnt;

endmodule

// File: tb/tb_deser5_rx.sv
// Bench for deser5_rx: one instance per bit order, driven in lockstep by a
// directed vector table and then by random traffic against a bit-queue model.
module tb_deser5_rx;
  import deser5_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  deser5_rx_if bus1 ();
  deser5_rx_if bus0 ();

  deser5_rx #(.LSBF(1'b1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  deser5_rx #(.LSBF(1'b0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));

  typedef struct {
    logic       rst, sdv, sdi, sclr, qr;
    logic [4:0] q1, q0;
    logic       qv, srdy;
    logic [2:0] cnt;
  } vec_t;

  vec_t       tbl[$];
  int         total = 0;
  int         bad   = 0;

  // reference model: accepted bits since the last word, plus the held word
  logic       m_bits[$];
  logic [4:0] m_q1, m_q0;
  logic       m_qv;
  logic [4:0] exp_q[$];

  task automatic add(input logic rst, sdv, sdi, sclr, qr,
                     input logic [4:0] q1, q0, input logic qv, srdy, input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.sdv = sdv; v.sdi = sdi; v.sclr = sclr; v.qr = qr;
    v.q1 = q1; v.q0 = q0; v.qv = qv; v.srdy = srdy; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [4:0] q, input logic qv, zn, srdy,
                           input logic [2:0] cnt, input logic [4:0] eq, input logic eqv,
                           input logic esrdy, input logic [2:0] ecnt);
    chk({tag, "_q"},    8'(q),    8'(eq));
    chk({tag, "_qv"},   8'(qv),   8'(eqv));
    chk({tag, "_zn"},   8'(zn),   8'(eq == 5'd0));
    chk({tag, "_srdy"}, 8'(srdy), 8'(esrdy));
    chk({tag, "_cnt"},  8'(cnt),  8'(ecnt));
  endtask

  function automatic logic [4:0] pack_bits(input bit lsbf);
    logic [4:0] w = '0;
    for (int i = 0; i < 5; i++) begin
      if (lsbf) w[i] = m_bits[i];
      else      w[4-i] = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_step(input logic rst, sdv, sdi, sclr, qr);
    logic loaded = 1'b0;
    logic consume;
    if (rst) begin
      m_bits.delete(); m_q1 = '0; m_q0 = '0; m_qv = 1'b0; exp_q.delete();
      return;
    end
    consume = m_qv && qr;
    if (sclr) begin
      m_bits.delete();
    end else if (m_bits.size() == 5) begin
      if (qr) loaded = 1'b1;
    end else if (sdv) begin
      m_bits.push_back(sdi);
      if (m_bits.size() == 5 && (!m_qv || qr)) loaded = 1'b1;
    end
    if (loaded) begin
      m_q1 = pack_bits(1'b1);
      m_q0 = pack_bits(1'b0);
      m_bits.delete();
      exp_q.push_back(m_q1);
      m_qv = 1'b1;
    end else if (consume) begin
      m_qv = 1'b0;
    end
  endtask

  task automatic drive(input logic rst, sdv, sdi, sclr, qr);
    logic       pre_qv;
    logic [4:0] pre_q, got;
    @(negedge CLK);
    RST = rst;
    bus1.SDV = sdv; bus1.SDI = sdv ? sdi : 1'bx; bus1.SCLR = sclr; bus1.QR = qr;
    bus0.SDV = sdv; bus0.SDI = sdv ? sdi : 1'bx; bus0.SCLR = sclr; bus0.QR = qr;
    pre_qv = bus1.QV;
    pre_q  = bus1.Q;
    @(posedge CLK);
    if (!rst && pre_qv && qr) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_word: got %0h want none (no word expected)", pre_q);
      end else begin
        got = exp_q.pop_front();
        chk("sb_word", 8'(pre_q), 8'(got));
      end
    end
    model_step(rst, sdv, sdi, sclr, qr);
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [2:0] mc = 3'(m_bits.size());
    logic       ms = (m_bits.size() != 5);
    chk_state({tag, "1"}, bus1.Q, bus1.QV, bus1.ZN, bus1.SRDY, bus1.CNT_DBG, m_q1, m_qv, ms, mc);
    chk_state({tag, "0"}, bus0.Q, bus0.QV, bus0.ZN, bus0.SRDY, bus0.CNT_DBG, m_q0, m_qv, ms, mc);
  endtask

  initial begin
    int qr_pct;
    bus1.SDV = 0; bus1.SDI = 0; bus1.SCLR = 0; bus1.QR = 0;
    bus0.SDV = 0; bus0.SDI = 0; bus0.SCLR = 0; bus0.QR = 0;

    //   rst sdv sdi scl qr   q1        q0        qv srdy cnt
    add(1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 0);
    // bits 1,0,1,1,0 with QR high
    add(0, 1, 1, 0, 1, 5'b00000, 5'b00000, 0, 1, 1);
    add(0, 1, 0, 0, 1, 5'b00000, 5'b00000, 0, 1, 2);
    add(0, 1, 1, 0, 1, 5'b00000, 5'b00000, 0, 1, 3);
    add(0, 1, 1, 0, 1, 5'b00000, 5'b00000, 0, 1, 4);
    add(0, 1, 0, 0, 1, 5'b01101, 5'b10110, 1, 1, 0);
    // all-zero word
    add(0, 1, 0, 0, 1, 5'b01101, 5'b10110, 0, 1, 1);
    add(0, 1, 0, 0, 1, 5'b01101, 5'b10110, 0, 1, 2);
    add(0, 1, 0, 0, 1, 5'b01101, 5'b10110, 0, 1, 3);
    add(0, 1, 0, 0, 1, 5'b01101, 5'b10110, 0, 1, 4);
    add(0, 1, 0, 0, 1, 5'b00000, 5'b00000, 1, 1, 0);
    add(0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 1, 0);
    // backpressure: word A 1,1,0,0,1 then word B 0,1,0,1,1 with QR low
    add(0, 1, 1, 0, 0, 5'b00000, 5'b00000, 0, 1, 1);
    add(0, 1, 1, 0, 0, 5'b00000, 5'b00000, 0, 1, 2);
    add(0, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 3);
    add(0, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 4);
    add(0, 1, 1, 0, 0, 5'b10011, 5'b11001, 1, 1, 0);
    add(0, 1, 0, 0, 0, 5'b10011, 5'b11001, 1, 1, 1);
    add(0, 1, 1, 0, 0, 5'b10011, 5'b11001, 1, 1, 2);
    add(0, 1, 0, 0, 0, 5'b10011, 5'b11001, 1, 1, 3);
    add(0, 1, 1, 0, 0, 5'b10011, 5'b11001, 1, 1, 4);
    add(0, 1, 1, 0, 0, 5'b10011, 5'b11001, 1, 0, 5);
    add(0, 1, 1, 0, 0, 5'b10011, 5'b11001, 1, 0, 5);
    add(0, 0, 0, 0, 1, 5'b11010, 5'b01011, 1, 1, 0);
    add(0, 0, 0, 0, 0, 5'b11010, 5'b01011, 1, 1, 0);
    // SCLR after 3 bits, then fresh word 1,0,0,0,0
    add(0, 1, 1, 0, 0, 5'b11010, 5'b01011, 1, 1, 1);
    add(0, 1, 1, 0, 0, 5'b11010, 5'b01011, 1, 1, 2);
    add(0, 1, 1, 0, 0, 5'b11010, 5'b01011, 1, 1, 3);
    add(0, 1, 0, 1, 0, 5'b11010, 5'b01011, 1, 1, 0);
    add(0, 1, 1, 0, 0, 5'b11010, 5'b01011, 1, 1, 1);
    add(0, 1, 0, 0, 0, 5'b11010, 5'b01011, 1, 1, 2);
    add(0, 1, 0, 0, 0, 5'b11010, 5'b01011, 1, 1, 3);
    add(0, 1, 0, 0, 0, 5'b11010, 5'b01011, 1, 1, 4);
    add(0, 1, 0, 0, 1, 5'b00001, 5'b10000, 1, 1, 0);
    // reset while a word is parked and Q is full
    add(0, 1, 1, 0, 0, 5'b00001, 5'b10000, 1, 1, 1);
    add(0, 1, 1, 0, 0, 5'b00001, 5'b10000, 1, 1, 2);
    add(0, 1, 1, 0, 0, 5'b00001, 5'b10000, 1, 1, 3);
    add(0, 1, 1, 0, 0, 5'b00001, 5'b10000, 1, 1, 4);
    add(0, 1, 1, 0, 0, 5'b00001, 5'b10000, 1, 0, 5);
    add(1, 1, 1, 0, 1, 5'b00000, 5'b00000, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].sdv, tbl[i].sdi, tbl[i].sclr, tbl[i].qr);
      chk_state($sformatf("row%0d_l1", i), bus1.Q, bus1.QV, bus1.ZN, bus1.SRDY, bus1.CNT_DBG,
                tbl[i].q1, tbl[i].qv, tbl[i].srdy, tbl[i].cnt);
      chk_state($sformatf("row%0d_l0", i), bus0.Q, bus0.QV, bus0.ZN, bus0.SRDY, bus0.CNT_DBG,
                tbl[i].q0, tbl[i].qv, tbl[i].srdy, tbl[i].cnt);
    end

    // sustained stream of 20 words with the consumer always ready
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1);
      chk_model("stream");
      chk("stream_srdy", 8'(bus1.SRDY), 8'd1);
    end

    // random traffic with varying consumer pressure
    qr_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) qr_pct = $urandom_range(0, 2) * 40 + 10;
      drive(1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 99) < qr_pct));
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
